// File: rtl/config_frame_writer.sv
// config_frame_writer: bitstream-side writer for the tile configuration memories.
// Accepts 32-bit words on a valid/ready stream, locks onto the sync word,
// decodes frame-write headers and drives FrameData, a one-hot FrameStrobe and a
// one-hot ColSelect towards the frame latch arrays of each tile column.
// Optional feature: define FRAME_COUNT_EN to add the saturating FrameCount output.
module config_frame_writer #(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfCols    = 16,
  parameter int StrobeCycles    = 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                WriteData,
  input  logic                       WriteValid,
  output logic                       WriteReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NumberOfCols-1:0]    ColSelect,
  output logic                       Synced,
  output logic                       HeaderError
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0]                FrameCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  localparam logic [31:0] SyncWord   = 32'hFAB0_FAB1;
  localparam logic [3:0]  OpWrite    = 4'h1;
  localparam logic [3:0]  OpDesync   = 4'hF;
  localparam logic [3:0]  StrobeLoad = 4'(StrobeCycles - 1);
  localparam logic [MaxFramesPerCol-1:0] FrameOne = MaxFramesPerCol'(1);
  localparam logic [NumberOfCols-1:0]    ColOne   = NumberOfCols'(1);

  state_t                     state_q, state_d;
  logic [7:0]                 colIdx_q, colIdx_d;
  logic [4:0]                 frameIdx_q, frameIdx_d;
  logic                       discard_q, discard_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic [NumberOfCols-1:0]    colSel_q, colSel_d;
  logic                       synced_q, synced_d;
  logic                       headerErr_q, headerErr_d;
  logic [3:0]                 cnt_q, cnt_d;

  logic                       readyState;
  logic                       accept;
  logic [31:0]                hdrCol;
  logic [31:0]                hdrFrame;
  logic                       hdrOk;

  // Words are only taken in the three stream-facing states; reset forces ready low.
  assign readyState = (state_q == S_IDLE) || (state_q == S_HEADER) || (state_q == S_DATA);
  assign accept     = WriteValid && readyState;
  assign WriteReady = readyState && !RESET;

  // Header indices widened so the range checks work for any parameter value.
  assign hdrCol   = {24'b0, WriteData[15:8]};
  assign hdrFrame = {27'b0, WriteData[4:0]};
  assign hdrOk    = (hdrCol < 32'(NumberOfCols)) && (hdrFrame < 32'(MaxFramesPerCol));

  // Next-state logic: stream decoding, frame sequencing and next strobe pattern.
  always_comb begin
    state_d     = state_q;
    colIdx_d    = colIdx_q;
    frameIdx_d  = frameIdx_q;
    discard_d   = discard_q;
    data_d      = data_q;
    synced_d    = synced_q;
    headerErr_d = headerErr_q;
    cnt_d       = cnt_q;
    strobe_d    = '0;
    colSel_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (accept && (WriteData == SyncWord)) begin
          state_d  = S_HEADER;
          synced_d = 1'b1;
        end
      end
      S_HEADER: begin
        // The sync word starts with the desync opcode, so it must be filtered first.
        if (accept && (WriteData != SyncWord)) begin
          if (WriteData[31:28] == OpWrite) begin
            colIdx_d   = WriteData[15:8];
            frameIdx_d = WriteData[4:0];
            discard_d  = !hdrOk;
            if (!hdrOk) begin
              headerErr_d = 1'b1;
            end
            state_d = S_DATA;
          end else if (WriteData[31:28] == OpDesync) begin
            state_d  = S_IDLE;
            synced_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (discard_q) begin
            state_d = S_HEADER;
          end else begin
            data_d  = WriteData[FrameBitsPerRow-1:0];
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = StrobeLoad;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_HEADER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_STROBE) begin
      strobe_d = FrameOne << frameIdx_q;
      colSel_d = ColOne << colIdx_q;
    end
  end

  // State and registered outputs; synchronous reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      colIdx_q    <= '0;
      frameIdx_q  <= '0;
      discard_q   <= 1'b0;
      data_q      <= '0;
      strobe_q    <= '0;
      colSel_q    <= '0;
      synced_q    <= 1'b0;
      headerErr_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      colIdx_q    <= colIdx_d;
      frameIdx_q  <= frameIdx_d;
      discard_q   <= discard_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      colSel_q    <= colSel_d;
      synced_q    <= synced_d;
      headerErr_q <= headerErr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign ColSelect   = colSel_q;
  assign Synced      = synced_q;
  assign HeaderError = headerErr_q;

`ifdef FRAME_COUNT_EN
  logic [15:0] frameCount_q;

  // Counts completed frames on entry to HOLD, saturating; only reset clears it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frameCount_q <= '0;
    end else if ((state_q == S_STROBE) && (state_d == S_HOLD) && (frameCount_q != 16'hFFFF)) begin
      frameCount_q <= frameCount_q + 16'd1;
    end
  end

  assign FrameCount = frameCount_q;
`endif

endmodule

// File: tb/tb_config_frame_writer.sv
// tb_config_frame_writer: randomized scoreboard bench for config_frame_writer.
// A word-level reference model predicts completed frames into a queue; a
// monitor pops and compares whenever the DUT raises a strobe.
module tb_config_frame_writer;

  localparam int MaxF      = 32;
  localparam int Bits      = 32;
  localparam int Cols      = 16;
  localparam int StrobeCyc = 4;
  localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;

  typedef struct {
    logic [31:0] data;
    int          frame;
    int          col;
  } frame_t;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [31:0]       WriteData;
  logic              WriteValid;
  logic              WriteReady;
  logic [Bits-1:0]   FrameData;
  logic [MaxF-1:0]   FrameStrobe;
  logic [Cols-1:0]   ColSelect;
  logic              Synced;
  logic              HeaderError;
`ifdef FRAME_COUNT_EN
  logic [15:0]       FrameCount;
`endif

  int errors = 0;
  int checks = 0;

  frame_t      expQ[$];
  bit          mSynced;
  bit          mHerr;
  bit          mExpectData;
  bit          mDiscard;
  int          mCol;
  int          mFrame;
  logic [31:0] mLastData;

  bit          inPulse   = 1'b0;
  bit          readyNext = 1'b0;
  int          pulseLen  = 0;
  logic [15:0] doneFrames = '0;
  frame_t      curExp;
  logic [31:0] expS;
  logic [31:0] expC;
  logic [31:0] prevData  = '0;
  logic        prevReady = 1'b0;

  config_frame_writer #(
    .MaxFramesPerCol(MaxF),
    .FrameBitsPerRow(Bits),
    .NumberOfCols(Cols),
    .StrobeCycles(StrobeCyc)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .WriteData(WriteData),
    .WriteValid(WriteValid),
    .WriteReady(WriteReady),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .ColSelect(ColSelect),
    .Synced(Synced),
    .HeaderError(HeaderError)
`ifdef FRAME_COUNT_EN
    ,
    .FrameCount(FrameCount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mSynced     = 1'b0;
    mHerr       = 1'b0;
    mExpectData = 1'b0;
    mDiscard    = 1'b0;
    mCol        = 0;
    mFrame      = 0;
    mLastData   = '0;
    expQ.delete();
  endtask

  // Word-level behaviour: what an accepted word means given the stream so far.
  task automatic modelWord(input logic [31:0] w);
    frame_t e;
    if (!mSynced) begin
      if (w == SyncWord) mSynced = 1'b1;
    end else if (mExpectData) begin
      mExpectData = 1'b0;
      if (!mDiscard) begin
        mLastData = w;
        e.data  = w;
        e.frame = mFrame;
        e.col   = mCol;
        expQ.push_back(e);
      end
    end else if (w == SyncWord) begin
      mSynced = 1'b1;
    end else if (w[31:28] == 4'h1) begin
      mCol        = int'(w[15:8]);
      mFrame      = int'(w[4:0]);
      mDiscard    = !((mCol < Cols) && (mFrame < MaxF));
      mExpectData = 1'b1;
      if (mDiscard) mHerr = 1'b1;
    end else if (w[31:28] == 4'hF) begin
      mSynced = 1'b0;
    end
  endtask

  // Offer one word with random idle gaps, wait for acceptance, then check state.
  task automatic applyStimulus(input logic [31:0] w);
    int guard;
    while ($urandom_range(0, 2) == 0) begin
      WriteValid = 1'b0;
      WriteData  = $urandom;
      @(negedge CLK);
    end
    WriteValid = 1'b1;
    WriteData  = w;
    guard      = 0;
    while ((WriteReady !== 1'b1) && (guard < 100)) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 100) begin
      checkOutput("accept_timeout", 32'(WriteReady), 32'd1);
      WriteValid = 1'b0;
    end else begin
      modelWord(w);
      @(negedge CLK);
      WriteValid = 1'b0;
      WriteData  = $urandom;
      checkOutput("synced", 32'(Synced), 32'(mSynced));
      checkOutput("header_error", 32'(HeaderError), 32'(mHerr));
      checkOutput("frame_data_held", FrameData, mLastData);
    end
  endtask

  task automatic sendFrame(input int col, input int frame, input logic [31:0] data);
    logic [31:0] h;
    h        = $urandom;
    h[31:28] = 4'h1;
    h[15:8]  = 8'(col);
    h[4:0]   = 5'(frame);
    applyStimulus(h);
    applyStimulus(data);
  endtask

  task automatic drain();
    int guard = 0;
    while (((expQ.size() != 0) || inPulse || readyNext) && (guard < 60)) begin
      @(negedge CLK);
      guard++;
    end
    checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: pops the expected frame at each strobe rising edge and checks the pulse.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        inPulse    = 1'b0;
        readyNext  = 1'b0;
        pulseLen   = 0;
        doneFrames = '0;
        prevData   = '0;
        prevReady  = 1'b0;
      end else begin
        checkOutput("colsel_pairing", 32'(ColSelect != '0), 32'(FrameStrobe != '0));
        if (FrameStrobe != '0) begin
          checkOutput("strobe_onehot", 32'($onehot0(FrameStrobe)), 32'd1);
          checkOutput("ready_in_strobe", 32'(WriteReady), 32'd0);
          if (!inPulse) begin
            inPulse  = 1'b1;
            pulseLen = 1;
            if (expQ.size() == 0) begin
              checkOutput("unexpected_strobe", FrameStrobe, 32'd0);
              curExp.data  = FrameData;
              curExp.frame = 0;
              curExp.col   = 0;
              expS = FrameStrobe;
              expC = 32'(ColSelect);
            end else begin
              curExp = expQ.pop_front();
              expS = 32'd1 << curExp.frame;
              expC = 32'd1 << curExp.col;
              checkOutput("setup_data", prevData, curExp.data);
              checkOutput("setup_ready", 32'(prevReady), 32'd0);
            end
          end else begin
            pulseLen++;
          end
          checkOutput("frame_strobe", FrameStrobe, expS);
          checkOutput("col_select", 32'(ColSelect), expC);
          checkOutput("strobe_data", FrameData, curExp.data);
        end else if (inPulse) begin
          inPulse = 1'b0;
          doneFrames = doneFrames + 16'd1;
          checkOutput("strobe_length", 32'(pulseLen), 32'(StrobeCyc));
          checkOutput("hold_ready", 32'(WriteReady), 32'd0);
          checkOutput("hold_data", FrameData, curExp.data);
`ifdef FRAME_COUNT_EN
          checkOutput("frame_count", 32'(FrameCount), 32'(doneFrames));
`endif
          readyNext = 1'b1;
        end else if (readyNext) begin
          readyNext = 1'b0;
          checkOutput("ready_after_hold", 32'(WriteReady), 32'd1);
        end
        prevData  = FrameData;
        prevReady = WriteReady;
      end
    end
  end

  // Stimulus: reset, directed scenarios, random stream, reset mid-strobe.
  initial begin
    logic [31:0] h;
    int guard;
    RESET      = 1'b1;
    WriteValid = 1'b0;
    WriteData  = '0;
    modelReset();
    repeat (2) @(negedge CLK);
    checkOutput("rst_ready", 32'(WriteReady), 32'd0);
    checkOutput("rst_data", FrameData, 32'd0);
    checkOutput("rst_strobe", FrameStrobe, 32'd0);
    checkOutput("rst_colsel", 32'(ColSelect), 32'd0);
    checkOutput("rst_synced", 32'(Synced), 32'd0);
    checkOutput("rst_herr", 32'(HeaderError), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("idle_ready", 32'(WriteReady), 32'd1);

    applyStimulus(32'h1000_0203);
    checkOutput("presync_ready", 32'(WriteReady), 32'd1);
    applyStimulus(32'hDEAD_BEEF);
    checkOutput("presync_ready", 32'(WriteReady), 32'd1);

    applyStimulus(SyncWord);
    applyStimulus(32'h1000_0305);
    applyStimulus(32'hA5A5_1234);
    applyStimulus(32'h1000_1400);
    applyStimulus(32'hFFFF_FFFF);
    applyStimulus(32'h1000_0101);
    applyStimulus(32'h0123_4567);
    applyStimulus(SyncWord);
    applyStimulus(32'hF000_0000);
    applyStimulus(32'h1000_0001);
    applyStimulus(32'h5555_AAAA);
    drain();

    applyStimulus(SyncWord);
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 8))
        0: applyStimulus($urandom);
        1, 8: applyStimulus(SyncWord);
        2, 3, 4: sendFrame($urandom_range(0, Cols - 1), $urandom_range(0, MaxF - 1), $urandom);
        5: sendFrame($urandom_range(Cols, 255), $urandom_range(0, MaxF - 1), $urandom);
        6: begin
          h = $urandom;
          h[31:28] = 4'hF;
          applyStimulus(h);
        end
        default: begin
          h = $urandom;
          h[31:28] = 4'($urandom_range(2, 14));
          applyStimulus(h);
        end
      endcase
    end
    drain();

    applyStimulus(SyncWord);
    sendFrame(7, 9, 32'hCAFE_0001);
    guard = 0;
    while ((FrameStrobe == '0) && (guard < 20)) begin
      @(negedge CLK);
      guard++;
    end
    checkOutput("strobe_before_reset", 32'(FrameStrobe != '0), 32'd1);
    RESET = 1'b1;
    modelReset();
    @(negedge CLK);
    checkOutput("midrst_strobe", FrameStrobe, 32'd0);
    checkOutput("midrst_colsel", 32'(ColSelect), 32'd0);
    checkOutput("midrst_synced", 32'(Synced), 32'd0);
    checkOutput("midrst_data", FrameData, 32'd0);
    checkOutput("midrst_herr", 32'(HeaderError), 32'd0);
    checkOutput("midrst_ready", 32'(WriteReady), 32'd0);
`ifdef FRAME_COUNT_EN
    checkOutput("midrst_count", 32'(FrameCount), 32'd0);
`endif
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("postrst_ready", 32'(WriteReady), 32'd1);
    applyStimulus(SyncWord);
    sendFrame(2, 31, 32'h1357_9BDF);
    sendFrame(15, 0, 32'h0F0F_F0F0);
    drain();
`ifdef FRAME_COUNT_EN
    checkOutput("final_count", 32'(FrameCount), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stalled handshake.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
